// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator-bank sequencer.
// State encodings and default bank geometry.
package acc_ctrl_pkg;

  localparam int ACC_NUM    = 8;
  localparam int ACC_KLEN_W = 8;

  typedef enum logic [1:0] {
    ACC_ST_IDLE  = 2'd0,
    ACC_ST_INIT  = 2'd1,
    ACC_ST_ACC   = 2'd2,
    ACC_ST_DRAIN = 2'd3
  } acc_st_e;

endpackage

// File: rtl/acc_drain_mux.sv
// Selects one accumulator from the bank for draining,
// as int16 or as sign-extended int8.
module acc_drain_mux #(
  parameter int NUM_ACC = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_ACC*16-1:0] acc_int16,
  input  logic [NUM_ACC*8-1:0]  acc_int8,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  int8,
  output logic [15:0]           data
);

  logic [15:0] w16;
  logic [7:0]  w8;

  // Concatenated bases keep the offset wide enough.
  assign w16  = acc_int16[{idx, 4'b0} +: 16];
  assign w8   = acc_int8[{idx, 3'b0} +: 8];
  assign data = int8 ? {{8{w8[7]}}, w8} : w16;

endmodule

// File: rtl/dffre.sv
// Generic register cell: async active-low reset to zero,
// synchronous load when en is high.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/acc_ctrl.sv
// Tile sequencer: clear/preload, accumulate beats,
// then drain the bank through a ready/valid port.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int NUM_ACC = ACC_NUM,
  parameter int KLEN_W  = ACC_KLEN_W,
  parameter int IDX_W   = $clog2(NUM_ACC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [KLEN_W-1:0]     cmd_klen,
  input  logic                  cmd_preload,
  input  logic                  cmd_int8,
  input  logic                  abort,
  input  logic                  psum_vld,
  output logic                  psum_rdy,
  output logic                  acc_clr,
  output logic                  load_vld,
  output logic                  acc_vld,
  input  logic [NUM_ACC*16-1:0] acc_int16,
  input  logic [NUM_ACC*8-1:0]  acc_int8,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [15:0]           out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy
);

  acc_st_e st, nxt;
  logic [1:0] st_q;

  logic [KLEN_W-1:0] klen_q;
  logic              pre_q;
  logic              i8_q;
  logic [KLEN_W-1:0] beat_cnt, bc_d;
  logic [IDX_W-1:0]  drain_idx, di_d;
  logic              cmd_hs, out_hs;
  logic              bc_en, di_en;

  assign st     = acc_st_e'(st_q);
  assign cmd_hs = cmd_vld & cmd_rdy;
  assign out_hs = out_vld & out_rdy;

  dffre #(.W(2)) u_st (
    .clk, .rst_n, .en(1'b1), .d(nxt), .q(st_q)
  );

  dffre #(.W(KLEN_W)) u_klen (
    .clk, .rst_n, .en(cmd_hs), .d(cmd_klen), .q(klen_q)
  );

  dffre #(.W(1)) u_pre (
    .clk, .rst_n, .en(cmd_hs), .d(cmd_preload), .q(pre_q)
  );

  dffre #(.W(1)) u_i8 (
    .clk, .rst_n, .en(cmd_hs), .d(cmd_int8), .q(i8_q)
  );

  // INIT zeroes the beat counter ahead of ACC.
  assign bc_en = (st == ACC_ST_INIT) | acc_vld;
  assign bc_d  = (st == ACC_ST_INIT) ? '0
               : beat_cnt + KLEN_W'(1);

  dffre #(.W(KLEN_W)) u_bc (
    .clk, .rst_n, .en(bc_en), .d(bc_d), .q(beat_cnt)
  );

  assign di_en = out_hs
               | ((st != ACC_ST_DRAIN) & (nxt == ACC_ST_DRAIN));
  assign di_d  = out_hs ? drain_idx + IDX_W'(1) : '0;

  dffre #(.W(IDX_W)) u_di (
    .clk, .rst_n, .en(di_en), .d(di_d), .q(drain_idx)
  );

  always_comb begin
    nxt      = st;
    cmd_rdy  = 1'b0;
    psum_rdy = 1'b0;
    acc_clr  = 1'b0;
    load_vld = 1'b0;
    out_vld  = 1'b0;
    unique case (st)
      ACC_ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) nxt = ACC_ST_INIT;
      end
      ACC_ST_INIT: begin
        acc_clr  = ~pre_q;
        load_vld = pre_q;
        nxt = (klen_q != '0) ? ACC_ST_ACC : ACC_ST_DRAIN;
      end
      ACC_ST_ACC: begin
        psum_rdy = 1'b1;
        if (psum_vld && beat_cnt == klen_q - KLEN_W'(1))
          nxt = ACC_ST_DRAIN;
      end
      ACC_ST_DRAIN: begin
        out_vld = 1'b1;
        if (out_rdy && out_last) nxt = ACC_ST_IDLE;
      end
      default: nxt = ACC_ST_IDLE;
    endcase
    // Abort wins over everything and silences all strobes.
    if (abort && st != ACC_ST_IDLE) begin
      nxt      = ACC_ST_IDLE;
      acc_clr  = 1'b0;
      load_vld = 1'b0;
      psum_rdy = 1'b0;
      out_vld  = 1'b0;
    end
  end

  assign acc_vld  = psum_vld & psum_rdy;
  assign out_idx  = drain_idx;
  assign out_last = (st == ACC_ST_DRAIN)
                  & (drain_idx == IDX_W'(NUM_ACC - 1));
  assign done     = out_hs & out_last;
  assign busy     = (st != ACC_ST_IDLE);

  acc_drain_mux #(
    .NUM_ACC(NUM_ACC),
    .IDX_W  (IDX_W)
  ) u_mux (
    .acc_int16(acc_int16),
    .acc_int8 (acc_int8),
    .idx      (drain_idx),
    .int8     (i8_q),
    .data     (out_data)
  );

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: bank model driven by the strobes,
// drain words checked against a scoreboard queue.
module tb_acc_ctrl;

  localparam int N  = 8;
  localparam int KW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [KW-1:0] cmd_klen = '0;
  logic          cmd_preload = 1'b0;
  logic          cmd_int8 = 1'b0;
  logic          abort = 1'b0;
  logic          psum_vld = 1'b0;
  logic          psum_rdy;
  logic          acc_clr, load_vld, acc_vld;
  logic [N*16-1:0] acc_int16;
  logic [N*8-1:0]  acc_int8;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [15:0]   out_data;
  logic [IW-1:0] out_idx;
  logic          out_last, done, busy;

  acc_ctrl #(.NUM_ACC(N), .KLEN_W(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_klen(cmd_klen), .cmd_preload(cmd_preload),
    .cmd_int8(cmd_int8), .abort(abort),
    .psum_vld(psum_vld), .psum_rdy(psum_rdy),
    .acc_clr(acc_clr), .load_vld(load_vld),
    .acc_vld(acc_vld),
    .acc_int16(acc_int16), .acc_int8(acc_int8),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          idx;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int bank[N];
  int pre_v[N];
  int cur_b = 0;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  int n_clr, n_load, n_acc, n_done, n_hs;
  int clr_t, load_t, acc_first_t, acc_last_t;
  int out_first_t, done_t;
  logic [15:0] d3;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sat8(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int pval(int b, int i);
    if (i == N - 1) return 20000;
    return (b + 1) * (i * 13 + 5) - 40;
  endfunction

  // Bank model reacts only to the DUT strobes.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (acc_clr) bank[i] <= 0;
      else if (load_vld) bank[i] <= pre_v[i];
      else if (acc_vld)
        bank[i] <= sat16(bank[i] + pval(cur_b, i));
    end
  end

  always_comb begin
    acc_int16 = '0;
    acc_int8  = '0;
    for (int i = 0; i < N; i++) begin
      acc_int16[16*i +: 16] = 16'(bank[i]);
      acc_int8[8*i +: 8]    = 8'(sat8(bank[i]));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (cmd_vld && cmd_rdy) begin
        t0 = cyc;
        n_clr = 0; n_load = 0; n_acc = 0;
        n_done = 0; n_hs = 0;
        clr_t = -1; load_t = -1; done_t = -1;
        acc_first_t = -1; acc_last_t = -1;
        out_first_t = -1;
      end
      if (acc_clr || load_vld || acc_vld)
        chk("strobe_mutex",
            32'(acc_clr) + 32'(load_vld) + 32'(acc_vld), 1);
      if (acc_clr) begin n_clr++; clr_t = cyc - t0; end
      if (load_vld) begin n_load++; load_t = cyc - t0; end
      if (acc_vld) begin
        n_acc++;
        if (acc_first_t < 0) acc_first_t = cyc - t0;
        acc_last_t = cyc - t0;
      end
      if (out_vld && out_first_t < 0) out_first_t = cyc - t0;
      if (out_vld && out_rdy) begin
        n_hs++;
        if (out_idx == 3) d3 = out_data;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_idx", 32'(out_idx), e.idx);
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
      if (done) begin
        n_done++;
        done_t = cyc - t0;
      end
    end
  end

  task automatic send_cmd(input int k, input bit pre,
                          input bit i8, input bit push);
    bit hs = 1'b0;
    exp_t x;
    int e;
    if (push) begin
      for (int i = 0; i < N; i++) begin
        e = pre ? pre_v[i] : 0;
        for (int b = 0; b < k; b++) e = sat16(e + pval(b, i));
        x.d = i8 ? 16'(sat8(e)) : 16'(e);
        x.idx = i;
        x.last = (i == N - 1);
        sb.push_back(x);
      end
    end
    @(posedge clk); #1;
    cmd_vld = 1'b1;
    cmd_klen = KW'(k);
    cmd_preload = pre;
    cmd_int8 = i8;
    for (int g = 0; g < 50 && !hs; g++) begin
      @(negedge clk);
      hs = cmd_rdy;
      @(posedge clk); #1;
    end
    cmd_vld = 1'b0;
    if (!hs) chk("cmd_timeout", 0, 1);
  endtask

  task automatic feed(input int k, input bit gaps);
    int b = 0;
    bit ph = 1'b1;
    bit take;
    if (k == 0) return;
    @(posedge clk); #1;
    for (int g = 0; g < 100 && b < k; g++) begin
      psum_vld = gaps ? ph : 1'b1;
      ph = ~ph;
      cur_b = b;
      @(negedge clk);
      take = psum_vld && psum_rdy;
      @(posedge clk); #1;
      if (take) b++;
    end
    psum_vld = 1'b0;
    if (b < k) chk("feed_timeout", b, k);
  endtask

  task automatic drain(input int stall);
    int sn = 0;
    logic [15:0] held = '0;
    for (int g = 0; g < 200 && n_done == 0; g++) begin
      if (out_vld && int'(out_idx) == stall && sn < 4) begin
        out_rdy = 1'b0;
        if (sn == 0) held = out_data;
        else begin
          chk("stall_data", 32'(out_data), 32'(held));
          chk("stall_idx", 32'(out_idx), stall);
        end
        sn++;
      end else begin
        out_rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    chk("done_seen", n_done, 1);
    chk("drain_words", n_hs, N);
    chk("sb_left", sb.size(), 0);
    if (stall >= 0) chk("stall_cycles", sn, 4);
  endtask

  task automatic tile_checks(input int k, input bit pre);
    chk("n_clr", n_clr, pre ? 0 : 1);
    chk("n_load", n_load, pre ? 1 : 0);
    chk("init_t", pre ? load_t : clr_t, 1);
    chk("n_acc", n_acc, k);
  endtask

  initial begin
    for (int i = 0; i < N; i++) pre_v[i] = i * 1000 - 3500;
    #1;
    chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_strobes",
        32'({out_vld, acc_clr, load_vld, acc_vld, psum_rdy}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // clear, 3 beats, int16 drain
    send_cmd(3, 1'b0, 1'b0, 1'b1);
    feed(3, 1'b0);
    drain(-1);
    tile_checks(3, 1'b0);
    chk("t1_acc_first", acc_first_t, 2);
    chk("t1_acc_last", acc_last_t, 4);
    chk("t1_out_first", out_first_t, 5);
    chk("t1_done_t", done_t, 12);

    // preload, klen=0, int8 negative saturation
    pre_v[3] = -300;
    send_cmd(0, 1'b1, 1'b1, 1'b1);
    drain(-1);
    tile_checks(0, 1'b1);
    chk("t2_out_first", out_first_t, 2);
    chk("t2_done_t", done_t, 9);
    chk("t2_i8_neg", 32'(d3), 32'hFF80);

    pre_v[3] = 200;
    send_cmd(0, 1'b1, 1'b1, 1'b1);
    drain(-1);
    chk("t3_i8_pos", 32'(d3), 32'h007F);

    // gapped beats, stall at drain index 2
    send_cmd(3, 1'b0, 1'b0, 1'b1);
    feed(3, 1'b1);
    drain(2);
    tile_checks(3, 1'b0);
    chk("t4_out_first", out_first_t, 7);

    // abort after one of five beats
    send_cmd(5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    psum_vld = 1'b1;
    cur_b = 0;
    @(posedge clk); #1;
    abort = 1'b1;
    #2;
    chk("abort_psum_rdy", 32'(psum_rdy), 0);
    chk("abort_acc_vld", 32'(acc_vld), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    psum_vld = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmd_rdy", 32'(cmd_rdy), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_n_acc", n_acc, 1);

    send_cmd(2, 1'b1, 1'b0, 1'b1);
    feed(2, 1'b0);
    drain(-1);
    tile_checks(2, 1'b1);
    chk("t5_done_t", done_t, 11);

    // reset in the middle of the drain
    send_cmd(1, 1'b0, 1'b0, 1'b1);
    feed(1, 1'b0);
    begin
      bit hit = 1'b0;
      for (int g = 0; g < 50 && !hit; g++) begin
        if (out_vld && out_idx == 3'd4) hit = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk("reach_idx4", 32'(hit), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_vld", 32'(out_vld), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_out_idx", 32'(out_idx), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_rdy", 32'(cmd_rdy), 1);
    chk("post_rst_out_idx", 32'(out_idx), 0);

    send_cmd(4, 1'b0, 1'b1, 1'b1);
    feed(4, 1'b0);
    drain(-1);
    tile_checks(4, 1'b0);
    chk("t6_done_t", done_t, 13);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
